// File: rtl/test_signal_generator.sv
// DDS-style test waveform source: phase accumulator, shape lookup and scaled/offset ADC-code output.
// Config reloads requested while running are deferred to the next phase wrap.
module test_signal_generator (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SAMPLE_TICK,
  input  logic       LOAD,
  input  logic       STOP,
  input  logic [15:0] FREQ_WORD,
  input  logic [1:0] WAVE_SEL,
  input  logic [8:0] AMPLITUDE,
  input  logic [8:0] OFFSET,
  output logic [8:0] DATA_OUT,
  output logic       DATA_VALID,
  output logic       SYNC_OUT,
  output logic       SIG_MODE,
  output logic       LOAD_ACK
);

  localparam int unsigned PH_W   = 16;
  localparam int unsigned SMP_W  = 9;
  localparam int unsigned PROD_W = 2 * SMP_W;
  localparam int unsigned SUM_W  = SMP_W + 1;
  localparam int unsigned MAX_CODE = 499;

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  typedef struct packed {
    logic [PH_W-1:0]  freq;
    logic [1:0]       wave;
    logic [SMP_W-1:0] amp;
    logic [SMP_W-1:0] offset;
  } cfg_t;

  typedef struct packed {
    logic [1:0]       wave;
    logic [SMP_W-1:0] amp;
    logic [SMP_W-1:0] offset;
  } shape_cfg_t;

  state_t           state_q, state_d;
  cfg_t             act_q, act_d, shd_q, shd_d, in_cfg;
  logic [PH_W-1:0]  ph_q, ph_d, ph_sum;
  logic             carry;
  logic             s1_valid_q, s1_valid_d, s1_sync_q, s1_sync_d;
  logic [SMP_W-1:0] s1_p_q, s1_p_d;
  shape_cfg_t       s1_cfg_q, s1_cfg_d;
  logic [SMP_W-1:0] data_d;
  logic             valid_d, sync_d, sig_mode_d, ack_d;
  logic             tick_run;

  logic [SMP_W-1:0]  u, tri_fall, scaled, sat;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

  assign in_cfg = '{freq: FREQ_WORD, wave: WAVE_SEL, amp: AMPLITUDE, offset: OFFSET};
  assign {carry, ph_sum} = {1'b0, ph_q} + {1'b0, act_q.freq};
  assign tick_run = SAMPLE_TICK && (state_q != IDLE) && !STOP;

  // Stage 2 datapath: shape value, amplitude scaling, offset and saturation.
  always_comb begin
    tri_fall = SMP_W'(9'd511 - s1_p_q);
    case (s1_cfg_q.wave)
      2'b01:   u = s1_p_q[SMP_W-1] ? '0 : SMP_W'(511);
      2'b10:   u = s1_p_q[SMP_W-1] ? {tri_fall[SMP_W-2:0], 1'b0} : {s1_p_q[SMP_W-2:0], 1'b0};
      2'b11:   u = s1_p_q;
      default: u = '0;
    endcase
    prod   = PROD_W'(u) * PROD_W'(s1_cfg_q.amp);
    scaled = SMP_W'(prod >> SMP_W);
    sum    = SUM_W'(s1_cfg_q.offset) + SUM_W'(scaled);
    sat    = (sum > SUM_W'(MAX_CODE)) ? SMP_W'(MAX_CODE) : sum[SMP_W-1:0];
  end

  // Next-state, config and pipeline control.
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    shd_d      = shd_q;
    ph_d       = ph_q;
    s1_valid_d = 1'b0;
    s1_sync_d  = 1'b0;
    s1_p_d     = s1_p_q;
    s1_cfg_d   = s1_cfg_q;
    data_d     = DATA_OUT;
    valid_d    = 1'b0;
    sync_d     = 1'b0;
    ack_d      = 1'b0;

    // The sample carries the config active at its own tick, so a reload at wrap affects only later ticks.
    if (tick_run) begin
      ph_d       = ph_sum;
      s1_valid_d = 1'b1;
      s1_sync_d  = carry;
      s1_p_d     = ph_sum[PH_W-1 -: SMP_W];
      s1_cfg_d   = '{wave: act_q.wave, amp: act_q.amp, offset: act_q.offset};
    end

    if (s1_valid_q && !STOP) begin
      valid_d = 1'b1;
      sync_d  = s1_sync_q;
      data_d  = sat;
    end

    if (STOP) begin
      state_d = IDLE;
      shd_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (LOAD) begin
          act_d   = in_cfg;
          ph_d    = '0;
          ack_d   = 1'b1;
          state_d = RUN;
        end
        RUN: if (LOAD) begin
          shd_d   = in_cfg;
          state_d = PEND;
        end
        PEND: if (tick_run && carry) begin
          act_d   = LOAD ? in_cfg : shd_q;
          shd_d   = '0;
          ack_d   = 1'b1;
          state_d = RUN;
        end else if (LOAD) begin
          shd_d = in_cfg;
        end
        default: state_d = IDLE;
      endcase
    end

    sig_mode_d = (state_d != IDLE) && (act_d.wave != 2'b00);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      act_q      <= '0;
      shd_q      <= '0;
      ph_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_sync_q  <= 1'b0;
      s1_p_q     <= '0;
      s1_cfg_q   <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      SYNC_OUT   <= 1'b0;
      SIG_MODE   <= 1'b0;
      LOAD_ACK   <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      shd_q      <= shd_d;
      ph_q       <= ph_d;
      s1_valid_q <= s1_valid_d;
      s1_sync_q  <= s1_sync_d;
      s1_p_q     <= s1_p_d;
      s1_cfg_q   <= s1_cfg_d;
      DATA_OUT   <= data_d;
      DATA_VALID <= valid_d;
      SYNC_OUT   <= sync_d;
      SIG_MODE   <= sig_mode_d;
      LOAD_ACK   <= ack_d;
    end
  end

endmodule

// File: tb/tb_test_signal_generator.sv
// Directed bench for test_signal_generator: latency, waveforms, saturation, deferred reload, STOP and reset.
module tb_test_signal_generator;

  logic       CLOCK, RESET, SAMPLE_TICK, LOAD, STOP;
  logic [15:0] FREQ_WORD;
  logic [1:0] WAVE_SEL;
  logic [8:0] AMPLITUDE, OFFSET;
  logic [8:0] DATA_OUT;
  logic       DATA_VALID, SYNC_OUT, SIG_MODE, LOAD_ACK;

  int vectors = 0;
  int miscompares = 0;

  logic       v, s, a;
  logic [8:0] d;

  test_signal_generator dut (
    .CLOCK(CLOCK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .LOAD(LOAD), .STOP(STOP),
    .FREQ_WORD(FREQ_WORD), .WAVE_SEL(WAVE_SEL), .AMPLITUDE(AMPLITUDE), .OFFSET(OFFSET),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .SYNC_OUT(SYNC_OUT),
    .SIG_MODE(SIG_MODE), .LOAD_ACK(LOAD_ACK)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic step;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_load(input logic [15:0] fw, input logic [1:0] ws,
                            input logic [8:0] amp, input logic [8:0] off);
    FREQ_WORD = fw; WAVE_SEL = ws; AMPLITUDE = amp; OFFSET = off;
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  task automatic do_stop;
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    step();
  endtask

  // One isolated tick; returns the sample seen two cycles later and the ack seen one cycle later.
  task automatic do_tick(output logic ov, output logic [8:0] od, output logic os, output logic oa);
    SAMPLE_TICK = 1'b1;
    step();
    oa = LOAD_ACK;
    SAMPLE_TICK = 1'b0;
    step();
    ov = DATA_VALID; od = DATA_OUT; os = SYNC_OUT;
  endtask

  initial begin
    RESET = 1'b0; SAMPLE_TICK = 1'b0; LOAD = 1'b0; STOP = 1'b0;
    FREQ_WORD = '0; WAVE_SEL = '0; AMPLITUDE = '0; OFFSET = '0;
    step(); step();
    check("rst_data", 16'(DATA_OUT), 16'd0);
    check("rst_valid", 16'(DATA_VALID), 16'd0);
    check("rst_sync", 16'(SYNC_OUT), 16'd0);
    check("rst_mode", 16'(SIG_MODE), 16'd0);
    check("rst_ack", 16'(LOAD_ACK), 16'd0);
    RESET = 1'b1;
    step();

    // Sawtooth, single tick latency: p=16 -> (16*511)>>9 = 15
    apply_load(16'h0800, 2'b11, 9'd511, 9'd0);
    check("saw_ack", 16'(LOAD_ACK), 16'd1);
    check("saw_mode", 16'(SIG_MODE), 16'd1);
    step();
    check("saw_ack_once", 16'(LOAD_ACK), 16'd0);
    SAMPLE_TICK = 1'b1;
    step();
    SAMPLE_TICK = 1'b0;
    check("lat_t1_valid", 16'(DATA_VALID), 16'd0);
    step();
    check("lat_t2_valid", 16'(DATA_VALID), 16'd1);
    check("lat_t2_data", 16'(DATA_OUT), 16'd15);
    check("lat_t2_sync", 16'(SYNC_OUT), 16'd0);
    step();
    check("lat_t3_valid", 16'(DATA_VALID), 16'd0);
    check("lat_hold", 16'(DATA_OUT), 16'd15);

    // Back-to-back ticks: p=32 -> 31, p=48 -> 47
    SAMPLE_TICK = 1'b1;
    step(); step();
    SAMPLE_TICK = 1'b0;
    check("b2b_v0", 16'(DATA_VALID), 16'd1);
    check("b2b_d0", 16'(DATA_OUT), 16'd31);
    step();
    check("b2b_v1", 16'(DATA_VALID), 16'd1);
    check("b2b_d1", 16'(DATA_OUT), 16'd47);
    step();
    check("b2b_end", 16'(DATA_VALID), 16'd0);

    // STOP with two samples in flight
    SAMPLE_TICK = 1'b1;
    step();
    STOP = 1'b1;
    step();
    STOP = 1'b0; SAMPLE_TICK = 1'b0;
    check("stop_valid0", 16'(DATA_VALID), 16'd0);
    check("stop_mode", 16'(SIG_MODE), 16'd0);
    check("stop_sync", 16'(SYNC_OUT), 16'd0);
    step();
    check("stop_valid1", 16'(DATA_VALID), 16'd0);
    check("stop_hold", 16'(DATA_OUT), 16'd47);
    do_tick(v, d, s, a);
    check("idle_tick", 16'(v), 16'd0);

    // Square AMP=400 OFF=50 FW=0x1000: high 449, low 50, sync every 16th
    apply_load(16'h1000, 2'b01, 9'd400, 9'd50);
    check("sq_ack", 16'(LOAD_ACK), 16'd1);
    for (int k = 1; k <= 32; k++) begin
      do_tick(v, d, s, a);
      check($sformatf("sq_v%0d", k), 16'(v), 16'd1);
      check($sformatf("sq_d%0d", k), 16'(d), ((k % 16) < 8) ? 16'd449 : 16'd50);
      check($sformatf("sq_s%0d", k), 16'(s), ((k % 16) == 0) ? 16'd1 : 16'd0);
    end

    // Deferred reload at PH=0x4000; takes effect only after the wrap
    for (int k = 1; k <= 4; k++) do_tick(v, d, s, a);
    apply_load(16'h1000, 2'b11, 9'd511, 9'd0);
    check("pend_no_ack", 16'(LOAD_ACK), 16'd0);
    for (int k = 5; k <= 16; k++) begin
      do_tick(v, d, s, a);
      check($sformatf("pend_a%0d", k), 16'(a), (k == 16) ? 16'd1 : 16'd0);
      check($sformatf("pend_d%0d", k), 16'(d), ((k % 16) < 8) ? 16'd449 : 16'd50);
      check($sformatf("pend_s%0d", k), 16'(s), (k == 16) ? 16'd1 : 16'd0);
    end
    do_tick(v, d, s, a);
    check("reload_data", 16'(d), 16'd31);
    check("reload_ack", 16'(a), 16'd0);
    check("reload_sync", 16'(s), 16'd0);

    // Saturation: 510+100 -> 499 high, 100 low
    do_stop();
    apply_load(16'h1000, 2'b01, 9'd511, 9'd100);
    do_tick(v, d, s, a);
    check("sat_high", 16'(d), 16'd499);
    for (int k = 2; k <= 7; k++) do_tick(v, d, s, a);
    do_tick(v, d, s, a);
    check("sat_low", 16'(d), 16'd100);

    // DC: output is the offset, SIG_MODE stays 0
    do_stop();
    apply_load(16'h1000, 2'b00, 9'd300, 9'd123);
    check("dc_ack", 16'(LOAD_ACK), 16'd1);
    check("dc_mode", 16'(SIG_MODE), 16'd0);
    do_tick(v, d, s, a);
    check("dc_valid", 16'(v), 16'd1);
    check("dc_data", 16'(d), 16'd123);

    // LOAD with tick in IDLE, freq=0: tick discarded, then constant level 10 without sync
    do_stop();
    FREQ_WORD = 16'h0000; WAVE_SEL = 2'b11; AMPLITUDE = 9'd511; OFFSET = 9'd10;
    LOAD = 1'b1; SAMPLE_TICK = 1'b1;
    step();
    LOAD = 1'b0; SAMPLE_TICK = 1'b0;
    check("lt_ack", 16'(LOAD_ACK), 16'd1);
    step();
    check("lt_no_sample0", 16'(DATA_VALID), 16'd0);
    step();
    check("lt_no_sample1", 16'(DATA_VALID), 16'd0);
    for (int k = 0; k < 3; k++) begin
      do_tick(v, d, s, a);
      check($sformatf("f0_v%0d", k), 16'(v), 16'd1);
      check($sformatf("f0_d%0d", k), 16'(d), 16'd10);
      check($sformatf("f0_s%0d", k), 16'(s), 16'd0);
    end

    // Reset mid-run with a sample in flight
    SAMPLE_TICK = 1'b1;
    step();
    SAMPLE_TICK = 1'b0; RESET = 1'b0;
    step();
    RESET = 1'b1;
    check("mr_data", 16'(DATA_OUT), 16'd0);
    check("mr_valid", 16'(DATA_VALID), 16'd0);
    check("mr_sync", 16'(SYNC_OUT), 16'd0);
    check("mr_mode", 16'(SIG_MODE), 16'd0);
    check("mr_ack", 16'(LOAD_ACK), 16'd0);
    step();
    check("mr_valid_after", 16'(DATA_VALID), 16'd0);
    do_tick(v, d, s, a);
    check("mr_idle_tick", 16'(v), 16'd0);
    apply_load(16'h1000, 2'b01, 9'd400, 9'd50);
    check("mr_reload_ack", 16'(LOAD_ACK), 16'd1);
    do_tick(v, d, s, a);
    check("mr_resume", 16'(d), 16'd449);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
